// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Data-memory stage behind the CPU MEM-stage port. A word-addressed RAM
//   sits behind a small in-order store buffer. Stores are queued, coalesced
//   and drained in the background, one RAM write per WCYC cycles. Loads see
//   the youngest value through combinational forwarding from the buffer.
//
// Ports
//   Clk    : clock, all state updates on the rising edge
//   Clrn   : synchronous active-low reset (buffer state only, RAM kept)
//   Daddr  : byte address; word address is Daddr[AW+1:2]
//   Dwrite : store data
//   Wmem   : store request
//   Dread  : load data for Daddr (combinational)
//   Stall  : store request not accepted this cycle (combinational)
//   Count  : registered buffer occupancy
//   Busy   : drain FSM is in WRITE
//   Empty  : Count == 0
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int WCYC  = 2
) (
    input  logic                     Clk,
    input  logic                     Clrn,
    input  logic [31:0]              Daddr,
    input  logic [31:0]              Dwrite,
    input  logic                     Wmem,
    output logic [31:0]              Dread,
    output logic                     Stall,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Busy,
    output logic                     Empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = (WCYC > 1) ? $clog2(WCYC) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WCYC - 1);
    localparam logic [PW:0]   CNT_FULL   = (PW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]   wa_q   [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     ram    [2**AW];

    logic [AW-1:0]   wa;
    logic            retire;
    logic            coalesce;
    logic            enqueue;
    logic            fwd_hit;
    logic [31:0]     fwd_data;
    logic [PW-1:0]   coal_idx;
    logic            unused_addr_bits;

    assign wa               = Daddr[AW+1:2];
    assign unused_addr_bits = ^{Daddr[31:AW+2], Daddr[1:0]};
    assign retire           = (state_q == WRITE) && (timer_q == '0);

    // Address match against the buffer. The retiring head is still a valid
    // forwarding source, but a store to it must not coalesce: the head's data
    // is being written to RAM on this edge, so the store becomes a new entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        coalesce = 1'b0;
        coal_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (wa_q[i] == wa)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[i];
                if (!((PW'(i) == head_q) && retire)) begin
                    coalesce = Wmem;
                    coal_idx = PW'(i);
                end
            end
        end
    end

    assign enqueue = Wmem && !coalesce && ((count_q < CNT_FULL) || retire);
    assign Stall   = Wmem && !coalesce && !enqueue;
    assign Dread   = fwd_hit ? fwd_data : ram[wa];
    assign Count   = count_q;
    assign Busy    = (state_q == WRITE);
    assign Empty   = (count_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        head_d  = head_q + PW'(retire);
        tail_d  = tail_q + PW'(enqueue);
        count_d = count_q + (PW + 1)'(enqueue) - (PW + 1)'(retire);
        valid_d = valid_q;
        // When full, tail equals head on a retire cycle; the set must win.
        if (retire)  valid_d[head_q] = 1'b0;
        if (enqueue) valid_d[tail_q] = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = WRITE;
                    timer_d = TIMER_LOAD;
                end
            end
            WRITE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (count_d != '0) begin
                    timer_d = TIMER_LOAD;
                end else begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q <= IDLE;
            timer_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload and RAM are not reset; reset only blocks their updates.
    always_ff @(posedge Clk) begin
        if (Clrn) begin
            if (coalesce) data_q[coal_idx] <= Dwrite;
            if (enqueue) begin
                wa_q[tail_q]   <= wa;
                data_q[tail_q] <= Dwrite;
            end
            if (retire) ram[wa_q[head_q]] <= data_q[head_q];
        end
    end

endmodule
